// File: rtl/kb_countdown_if.sv
// kb_countdown_if: key events and tick in; BCD display word and status out
interface kb_countdown_if;
  logic         tick;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [15:0]  nums;
  logic [1:0]   state_o;
  logic         done;
  logic [2:0]   digit_cnt;
  modport master (output tick, key_valid, last_change, key_down, input nums, state_o, done, digit_cnt);
  modport slave  (input tick, key_valid, last_change, key_down, output nums, state_o, done, digit_cnt);
endinterface

// File: rtl/kb_countdown_ctrl.sv
// kb_countdown_ctrl: keyboard-driven 4-digit BCD countdown timer
module kb_countdown_ctrl #(
  parameter logic [8:0] KEY_ENTER = 9'h05A,
  parameter logic [8:0] KEY_BKSP  = 9'h066,
  parameter logic [8:0] KEY_SPACE = 9'h029,
  parameter logic [8:0] KEY_ESC   = 9'h076
) (
  input logic         clk,
  input logic         rst,
  kb_countdown_if.slave bus
);
  typedef enum logic [1:0] {EDIT = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t      state;
  logic [15:0] ent, timer;
  logic [2:0]  cnt;
  logic        done_q;
  logic        press, is_dig, is_enter, is_bksp, is_space, is_esc;
  logic [3:0]  dig;
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction
  always_comb begin
    is_dig = 1'b1;
    dig = 4'd0;
    case (bus.last_change)
      9'h045, 9'h070: dig = 4'd0;
      9'h016, 9'h069: dig = 4'd1;
      9'h01E, 9'h072: dig = 4'd2;
      9'h026, 9'h07A: dig = 4'd3;
      9'h025, 9'h06B: dig = 4'd4;
      9'h02E, 9'h073: dig = 4'd5;
      9'h036, 9'h074: dig = 4'd6;
      9'h03D, 9'h06C: dig = 4'd7;
      9'h03E, 9'h075: dig = 4'd8;
      9'h046, 9'h07D: dig = 4'd9;
      default: is_dig = 1'b0;
    endcase
  end
  assign press    = bus.key_valid && bus.key_down[bus.last_change];
  assign is_enter = press && (bus.last_change == KEY_ENTER || bus.last_change == 9'h15A);
  assign is_bksp  = press && bus.last_change == KEY_BKSP;
  assign is_space = press && bus.last_change == KEY_SPACE;
  assign is_esc   = press && bus.last_change == KEY_ESC;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EDIT;
      ent    <= 16'h0000;
      timer  <= 16'h0000;
      cnt    <= 3'd0;
      done_q <= 1'b0;
    end else begin
      case (state)
        EDIT: begin
          if (press && is_dig && cnt < 3'd4) begin
            ent <= {ent[11:0], dig};
            cnt <= cnt + 3'd1;
          end else if (is_bksp) begin
            ent <= {4'h0, ent[15:4]};
            cnt <= (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
          end else if (is_enter && ent != 16'h0000) begin
            timer <= ent;
            state <= RUN;
          end else if (is_esc) begin
            ent <= 16'h0000;
            cnt <= 3'd0;
          end
        end
        RUN: begin
          if (is_space) state <= PAUSE;
          else if (is_esc) begin
            state <= EDIT;
            ent   <= 16'h0000;
            cnt   <= 3'd0;
            timer <= 16'h0000;
          end else if (bus.tick) begin
            timer <= (timer == 16'h0001) ? 16'h0000 : bcd_dec(timer);
            if (timer == 16'h0001) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (is_space) state <= RUN;
          else if (is_esc) begin
            state <= EDIT;
            ent   <= 16'h0000;
            cnt   <= 3'd0;
            timer <= 16'h0000;
          end
        end
        DONE: begin
          if (is_enter) begin
            timer  <= ent;
            state  <= RUN;
            done_q <= 1'b0;
          end else if (is_esc) begin
            state  <= EDIT;
            ent    <= 16'h0000;
            cnt    <= 3'd0;
            timer  <= 16'h0000;
            done_q <= 1'b0;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end
  assign bus.nums      = (state == EDIT) ? ent : (state == DONE) ? 16'h0000 : timer;
  assign bus.state_o   = state;
  assign bus.done      = done_q;
  assign bus.digit_cnt = cnt;
endmodule

// File: tb/tb_kb_countdown_ctrl.sv
// tb_kb_countdown_ctrl: directed key/tick stimulus with a queued expectation scoreboard
module tb_kb_countdown_ctrl;
  typedef struct packed {
    logic [15:0] n;
    logic [1:0]  s;
    logic [2:0]  c;
    logic        d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  kb_countdown_if bus ();
  kb_countdown_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  string names[$];
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e, a;
      string nm;
      e = q.pop_front();
      nm = names.pop_front();
      a = {bus.nums, bus.state_o, bus.digit_cnt, bus.done};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got nums=%h st=%b cnt=%0d done=%b, want nums=%h st=%b cnt=%0d done=%b",
                 nm, a.n, a.s, a.c, a.d, e.n, e.s, e.c, e.d);
      end
    end
  end
  task automatic expect_out(input string nm, input logic [15:0] n, input logic [1:0] s,
                            input logic [2:0] c, input logic d);
    q.push_back({n, s, c, d});
    names.push_back(nm);
  endtask
  task automatic key(input logic [8:0] code, input logic down = 1'b1, input logic t = 1'b0);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b1;
    bus.last_change = code;
    bus.key_down = '0;
    bus.key_down[code] = down;
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.tick = 1'b0;
  endtask
  task automatic tick(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
    end
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.key_valid = 1'b0;
    bus.last_change = '0;
    bus.key_down = '0;
    expect_out("reset", 16'h0000, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    key(9'h016); key(9'h01E); key(9'h026);
    expect_out("type123", 16'h0123, 2'b00, 3'd3, 1'b0);
    key(9'h01C);
    expect_out("unlisted", 16'h0123, 2'b00, 3'd3, 1'b0);
    key(9'h076);
    expect_out("esc_edit", 16'h0000, 2'b00, 3'd0, 1'b0);
    key(9'h016); key(9'h01E); key(9'h026); key(9'h025); key(9'h02E);
    expect_out("fifth_ignored", 16'h1234, 2'b00, 3'd4, 1'b0);
    key(9'h066);
    expect_out("bksp", 16'h0123, 2'b00, 3'd3, 1'b0);
    key(9'h076);
    key(9'h069); key(9'h070);
    expect_out("kp10", 16'h0010, 2'b00, 3'd2, 1'b0);
    key(9'h05A);
    expect_out("enter_run", 16'h0010, 2'b01, 3'd2, 1'b0);
    tick();
    expect_out("tick_0009", 16'h0009, 2'b01, 3'd2, 1'b0);
    tick(8);
    expect_out("tick_0001", 16'h0001, 2'b01, 3'd2, 1'b0);
    tick();
    expect_out("done", 16'h0000, 2'b11, 3'd2, 1'b1);
    tick(2);
    expect_out("done_tick_ign", 16'h0000, 2'b11, 3'd2, 1'b1);
    key(9'h05A);
    expect_out("restart", 16'h0010, 2'b01, 3'd2, 1'b0);
    key(9'h076);
    expect_out("esc_run", 16'h0000, 2'b00, 3'd0, 1'b0);
    key(9'h05A);
    expect_out("enter_zero", 16'h0000, 2'b00, 3'd0, 1'b0);
    key(9'h016); key(9'h045); key(9'h045); key(9'h045);
    expect_out("type1000", 16'h1000, 2'b00, 3'd4, 1'b0);
    key(9'h15A);
    expect_out("kp_enter", 16'h1000, 2'b01, 3'd4, 1'b0);
    tick();
    expect_out("borrow", 16'h0999, 2'b01, 3'd4, 1'b0);
    key(9'h029);
    expect_out("pause", 16'h0999, 2'b10, 3'd4, 1'b0);
    tick(3);
    expect_out("pause_hold", 16'h0999, 2'b10, 3'd4, 1'b0);
    key(9'h029);
    expect_out("resume", 16'h0999, 2'b01, 3'd4, 1'b0);
    tick();
    expect_out("tick_0998", 16'h0998, 2'b01, 3'd4, 1'b0);
    key(9'h029, 1'b0);
    expect_out("release_ign", 16'h0998, 2'b01, 3'd4, 1'b0);
    key(9'h016); key(9'h066);
    expect_out("run_keys_ign", 16'h0998, 2'b01, 3'd4, 1'b0);
    key(9'h076);
    key(9'h02E); key(9'h045); key(9'h05A);
    expect_out("run0050", 16'h0050, 2'b01, 3'd2, 1'b0);
    key(9'h029, 1'b1, 1'b1);
    expect_out("space_tick", 16'h0050, 2'b10, 3'd2, 1'b0);
    key(9'h029);
    key(9'h016, 1'b1, 1'b1);
    expect_out("digit_tick", 16'h0049, 2'b01, 3'd2, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 16'h0000, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    key(9'h05A);
    expect_out("post_rst", 16'h0000, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kb_countdown_ctrl.md
Name: kb_countdown_ctrl

Overview:
- Consumes key events from the PS/2 keyboard decoder and turns them into a 4-digit BCD countdown timer.
- Digits are typed into an entry buffer. Enter starts the countdown, Space pauses and resumes it, Esc aborts it.
- Produces the 16-bit BCD word fed to the SevenSegment driver, plus status for LEDs.
- Sits between KeyboardDecoder (upstream) and SevenSegment / led logic (downstream).

Parameters:
- KEY_ENTER, 9'h05A, main Enter code; keypad Enter 9'h15A is also accepted.
- KEY_BKSP, 9'h066, Backspace code.
- KEY_SPACE, 9'h029, Space code.
- KEY_ESC, 9'h076, Escape code.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle pulse setting the countdown rate (e.g. 1 Hz from the clock divider)
- key_valid  in  1  one-cycle pulse from the decoder on any press or release
- last_change  in  9  {extend, code} of the key that changed
- key_down  in  512  decoder key-state vector, already updated in the key_valid cycle
- nums  out  16  four BCD digits to the display; [15:12] is the leftmost digit
- state_o  out  2  00 EDIT, 01 RUN, 10 PAUSE, 11 DONE
- done  out  1  high while in DONE
- digit_cnt  out  3  number of digits typed, 0..4

Behaviour:
- Reset (async): state EDIT; ent=0, timer=0, digit_cnt=0, done=0, nums=16'h0000.
- Press event: key_valid && key_down[last_change]. Release events are ignored. Unlisted codes are ignored.
- Digit codes, extend bit = 0:
  - Main row 0-9: 45,16,1E,26,25,2E,36,3D,3E,46.
  - Keypad 0-9: 70,69,72,7A,6B,73,74,6C,75,7D.
- Events are registered on the edge where key_valid is sampled high; nums and state_o reflect them from that edge onward.
- nums (combinational): EDIT shows ent; RUN and PAUSE show timer; DONE shows 16'h0000.

EDIT state:
- Digit with digit_cnt<4: ent <= {ent[11:0], d}; digit_cnt+1.
- Digit with digit_cnt==4: ignored.
- Backspace: ent <= {4'h0, ent[15:4]}; digit_cnt-1, saturating at 0.
- Enter with ent!=0: timer <= ent; go to RUN.
- Enter with ent==0: ignored.
- Esc: ent=0, digit_cnt=0.
- tick is ignored.

RUN state:
- On tick: BCD decrement with borrow; a digit at 0 becomes 9 and borrows from the next digit.
- If timer==16'h0001 on tick: timer <= 0; go to DONE.
- Space: go to PAUSE.
- Esc: go to EDIT; ent=0, digit_cnt=0.
- Digits, Backspace and Enter are ignored.

PAUSE state:
- tick is ignored; timer holds.
- Space: go to RUN.
- Esc: go to EDIT, cleared.

DONE state:
- done=1.
- Enter: timer <= ent (ent is retained through RUN, PAUSE and DONE); go to RUN, which restarts the countdown.
- Esc: go to EDIT, cleared.
- All other keys and tick are ignored.

Corner cases:
- Simultaneous key press and tick in the same cycle: the key action wins; if it changes state, that tick is dropped. Non-transition keys do not block the tick.
- Timer can never hold non-BCD values, because ent is built only from digits 0..9.
- rst mid-countdown returns to EDIT immediately with all registers cleared.

Test Plan:
- Reset, then press 1,2,3 (16,1E,26) -> nums=16'h0123, digit_cnt=3, state_o=00.
- Press 1,2,3,4,5 -> nums=16'h1234 (fifth digit ignored). Backspace -> nums=16'h0123, digit_cnt=3.
- Enter ent 0010 (keypad 69,70) plus Enter, then tick -> 0009, 0008 … 0001, then next tick -> nums=0000, done=1, state_o=11. Enter -> nums=0010, state RUN.
- Enter ent 1000; one tick -> 0999 (full borrow chain). Space -> PAUSE; 3 ticks -> still 0999. Space -> RUN; tick -> 0998.
- Space press and tick in the same cycle with timer 0050 -> PAUSE, timer stays 0050. Key releases (key_valid with key_down bit 0) produce no change.
- Esc during RUN -> EDIT, nums=0000, digit_cnt=0. Enter with ent=0 -> stays EDIT. Async rst mid-RUN -> all outputs 0, state EDIT.
